// File: rtl/mult_pkg.sv
// Shared definitions for the 4x4 shift-and-add multiplier path.
// Holds the controller state encoding, the default operand width and the
// derived product / counter widths used by seq_mult_ctrl and its neighbours.
package mult_pkg;

  localparam int N_DEF      = 4;
  localparam int PROD_W_DEF = 2 * N_DEF;
  // Counter must reach 2N-1 during the drain phase.
  localparam int CNT_W_DEF  = $clog2(2 * N_DEF + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    LOAD  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } mult_state_t;

endpackage

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-and-add multiplier plus serializer controller.
// Accepts two unsigned N-bit operands on start, builds the 2N-bit product
// over N cycles, presents it with a one-cycle load strobe for the PISO, then
// holds the PISO shift enable for 2N cycles before returning to idle.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       synchronous active-low reset
//   start         operation request, honoured only in IDLE
//   a, b          multiplicand / multiplier, captured when start is accepted
//   busy          high in every non-IDLE state
//   product       registered 2N-bit result (PISO data_in)
//   product_valid one-cycle strobe while in LOAD
//   piso_on       PISO load strobe, same timing as product_valid
//   piso_enable   PISO shift enable, high for the 2N DRAIN cycles
//   done          one-cycle pulse in DONE
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic [2*N-1:0] product,
  output logic           product_valid,
  output logic           piso_on,
  output logic           piso_enable,
  output logic           done
);

  localparam int PW    = 2 * N;
  localparam int CNT_W = $clog2(2 * N + 1);

  mult_state_t      state;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [N-1:0]     mplr;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    acc_sum;

  // Accumulator value after the current partial product; also what product
  // latches on the final RUN edge so it is already stable on entry to LOAD.
  always_comb begin
    acc_sum = acc;
    if (mplr[0]) acc_sum = acc + mcand;
  end

  // Outputs are registered and updated on the same edge as the state change,
  // so each one lines up exactly with the state it belongs to.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      acc           <= '0;
      mcand         <= '0;
      mplr          <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      product       <= '0;
      product_valid <= 1'b0;
      piso_on       <= 1'b0;
      piso_enable   <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= {{N{1'b0}}, a};
            mplr  <= b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          acc   <= acc_sum;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) begin
            product       <= acc_sum;
            product_valid <= 1'b1;
            piso_on       <= 1'b1;
            state         <= LOAD;
          end
        end

        LOAD: begin
          product_valid <= 1'b0;
          piso_on       <= 1'b0;
          piso_enable   <= 1'b1;
          cnt           <= '0;
          state         <= DRAIN;
        end

        DRAIN: begin
          if (cnt == CNT_W'(PW - 1)) begin
            piso_enable <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_mult_ctrl.md
# seq_mult_ctrl

Sequential shift-and-add multiplier and serializer controller, the stage directly upstream of the 8-bit PISO in the 4x4 multiplier design. It accepts two 4-bit operands on a start pulse and computes the 8-bit product over N cycles. It then presents the product with a one-cycle load strobe for the PISO. Finally it drives the PISO shift enable for exactly 2N cycles, so the full product leaves the serializer LSB first before the next operation is accepted.

## Interface
- N, default 4: operand width; product width 2N; serializer drain length 2N cycles.
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- a  in  N  multiplicand; captured when start is accepted.
- b  in  N  multiplier; captured when start is accepted.
- busy  out  1  high in every non-IDLE state.
- product  out  2N  registered result; drives PISO data_in.
- product_valid  out  1  one-cycle strobe in LOAD.
- piso_on  out  1  PISO load strobe; identical timing to product_valid.
- piso_enable  out  1  PISO shift enable; high only in DRAIN.
- done  out  1  one-cycle pulse in DONE.

## Operation
- States: IDLE, RUN, LOAD, DRAIN, DONE.
- IDLE:
  - start=1 captures mcand={N'b0,a} (2N wide), mplr=b, clears acc (2N), clears cnt, and moves to RUN.
  - start=0 stays in IDLE.
- RUN, one partial product per cycle:
  - if mplr[0], acc <= acc + mcand;
  - mcand <= mcand << 1; mplr <= mplr >> 1; cnt++.
  - After N RUN cycles, go to LOAD.
- Arithmetic is unsigned. acc never overflows 2N bits: max (2^N-1)^2, which is 0xE1 for N=4.
- LOAD:
  - product <= acc on entry, so product is stable throughout LOAD.
  - product_valid=1, piso_on=1.
  - Go to DRAIN and clear cnt.
- DRAIN: piso_enable=1 for exactly 2N cycles, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- product holds its value from LOAD until the next LOAD. It is unaffected by a new start until that LOAD.
- start outside IDLE is ignored: no queuing and no error. This includes start in the DONE cycle.
- a and b may change freely after capture.
- reset_n=0 at any clock edge, including mid-RUN or mid-DRAIN, forces IDLE and abandons the operation with no done. After reset:
  - busy, product, product_valid, piso_on, piso_enable, done are all 0;
  - acc, mcand, mplr, cnt are 0.

## Timing
- Start accepted at edge ending cycle T (IDLE, start=1).
- Cycle schedule:
  - RUN: T+1 .. T+N.
  - LOAD: T+N+1, with product valid and piso_on=1.
  - DRAIN: T+N+2 .. T+3N+1.
  - DONE: T+3N+2.
  - IDLE: T+3N+3.
- For N=4: LOAD at T+5, DRAIN at T+6..T+13, DONE at T+14, IDLE at T+15.
- busy is high T+1 .. T+3N+2. Next start is accepted no earlier than the edge ending T+3N+3.
- Continuous start=1 gives one accepted operation every 3N+3 cycles (15 for N=4).
- PISO view:
  - load occurs at the edge ending LOAD.
  - product bit k appears on serial_out after the edge ending DRAIN cycle k (k=0..2N-1).
  - The last bit is valid during DONE.
- All outputs are registered or decoded directly from state. No combinational path from start, a or b to any output.

## Structure
- Shared package mult_pkg holds:
  - the state enum (IDLE, RUN, LOAD, DRAIN, DONE);
  - the default N=4 and product width 2N;
  - counter width $clog2(2N+1).
- Single module. FSM and datapath (acc, mcand, mplr, cnt) are inline; no sub-module needed.
- Top level connects product to PISO data_in, piso_on to piso_on, and piso_enable to piso_enable.

## Test plan
- a=0xF, b=0xF, start at T: product=0xE1 with product_valid=piso_on=1 exactly at T+5. The PISO serial_out sequence over T+7..T+14 is 1,0,0,0,0,1,1,1.
- a=0x5, b=0x3, then a=0x0, b=0x9, then a=0xA, b=0x0: products 0x0F, 0x00, 0x00. Each operation shows busy high for 14 cycles and done a single pulse at T+14.
- start held high continuously for 40 cycles: accepts at T, T+15, T+30 only. a/b changes between accepts are ignored, as is start during DONE.
- start pulsed at T+3 and T+10 of an active operation: no effect on product, state sequence, or done count.
- reset_n=0 for one cycle during DRAIN (T+9): next cycle all outputs 0 and state IDLE, no done pulse. A new start=1 with a=2, b=3 then yields product=0x06 at LOAD.
- Exhaustive sweep of all 256 a/b pairs: product == a*b at every LOAD, piso_enable high for exactly 8 cycles per operation, and piso_on never coincides with piso_enable.
